// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the SRAM channel arbiter slice.
package sram_arb_pkg;

    localparam int SRAM_ADDR_W_DEFAULT = 24;
    localparam int SRAM_INST_W         = 8;

    localparam logic [7:0] SRAM_INST_NONE  = 8'd0;
    localparam logic [7:0] SRAM_INST_WRITE = 8'd2;
    localparam logic [7:0] SRAM_INST_READ  = 8'd3;

    typedef enum logic [1:0] {
        CH_IDLE    = 2'd0,
        CH_BUSY    = 2'd1,
        CH_HOLDOFF = 2'd2
    } ch_state_t;

    // Round-robin successor of the last owner, wrapping to requester 0.
    function automatic int rr_next(input int owner, input int num_req);
        return (owner + 1 >= num_req) ? 0 : owner + 1;
    endfunction

endpackage

// File: rtl/sram_channel_arbiter_if.sv
// Engine-side and controller-side buses of the arbiter, flattened per requester/channel.
interface sram_channel_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = SRAM_ADDR_W_DEFAULT
);
    logic [NUM_REQ*NUM_CH-1:0]             req;
    logic [NUM_REQ*NUM_CH*SRAM_INST_W-1:0] req_inst;
    logic [NUM_REQ*NUM_CH*ADDR_W-1:0]      req_address;
    logic [NUM_REQ*NUM_CH*ADDR_W-1:0]      req_byte_length;
    logic [NUM_REQ*NUM_CH-1:0]             req_write_in;
    logic [NUM_REQ*NUM_CH-1:0]             grant;
    logic [NUM_REQ*NUM_CH-1:0]             gnt_io_valid;
    logic [NUM_REQ*NUM_CH-1:0]             gnt_mem_out;
    logic [NUM_REQ*NUM_CH-1:0]             gnt_rw_done;
    logic [NUM_CH*SRAM_INST_W-1:0]         inst;
    logic [NUM_CH*ADDR_W-1:0]              address;
    logic [NUM_CH*ADDR_W-1:0]              byte_length;
    logic [NUM_CH-1:0]                     write_in;
    logic [NUM_CH-1:0]                     io_valid;
    logic [NUM_CH-1:0]                     mem_out;
    logic [NUM_CH-1:0]                     rw_done;

    modport slave (
        input  req, req_inst, req_address, req_byte_length, req_write_in,
        input  io_valid, mem_out, rw_done,
        output grant, gnt_io_valid, gnt_mem_out, gnt_rw_done,
        output inst, address, byte_length, write_in
    );

    modport master (
        output req, req_inst, req_address, req_byte_length, req_write_in,
        output io_valid, mem_out, rw_done,
        input  grant, gnt_io_valid, gnt_mem_out, gnt_rw_done,
        input  inst, address, byte_length, write_in
    );

endinterface

// File: rtl/sram_channel_arbiter_slot.sv
// One SRAM channel: round-robin ownership FSM, owned-cycle watchdog and owner mux.
module sram_channel_slot
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_W         = SRAM_ADDR_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*SRAM_INST_W-1:0]  req_inst,
    input  logic [NUM_REQ*ADDR_W-1:0]       req_address,
    input  logic [NUM_REQ*ADDR_W-1:0]       req_byte_length,
    input  logic [NUM_REQ-1:0]              req_write_in,
    input  logic                            io_valid,
    input  logic                            mem_out,
    input  logic                            rw_done,
    input  logic                            err_clr,
    output logic [NUM_REQ-1:0]              grant,
    output logic [NUM_REQ-1:0]              gnt_io_valid,
    output logic [NUM_REQ-1:0]              gnt_mem_out,
    output logic [NUM_REQ-1:0]              gnt_rw_done,
    output logic [SRAM_INST_W-1:0]          inst,
    output logic [ADDR_W-1:0]               address,
    output logic [ADDR_W-1:0]               byte_length,
    output logic                            write_in,
    output logic                            timeout_err
);

    localparam int          OWN_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] TO_SAT  = 32'(TIMEOUT_CYCLES);

    ch_state_t        state_r;
    logic [OWN_W-1:0] owner_r;
    logic [OWN_W-1:0] rr_ptr_r;
    logic [31:0]      cnt_r;
    logic [OWN_W-1:0] pick_s;
    logic             pick_valid_s;
    logic             owner_req_s;
    logic             timeout_hit_s;

    assign owner_req_s   = req[owner_r];
    assign timeout_hit_s = (state_r == CH_BUSY) && owner_req_s && !rw_done && (cnt_r == TO_LAST);

    // Round-robin pick: scan from the far end so the smallest offset from rr_ptr wins.
    always_comb begin
        int idx;
        idx          = 0;
        pick_s       = rr_ptr_r;
        pick_valid_s = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx          = (int'(rr_ptr_r) + i) % NUM_REQ;
            pick_s       = req[idx] ? OWN_W'(idx) : pick_s;
            pick_valid_s = pick_valid_s | req[idx];
        end
    end

    // Ownership FSM, owned-cycle counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= CH_IDLE;
            owner_r  <= '0;
            rr_ptr_r <= '0;
            cnt_r    <= 32'd0;
        end else begin
            case (state_r)
                CH_IDLE: begin
                    if (pick_valid_s) begin
                        state_r <= CH_BUSY;
                        owner_r <= pick_s;
                        cnt_r   <= 32'd0;
                    end
                end
                CH_BUSY: begin
                    if (cnt_r < TO_SAT) begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                    // Completion, abort and watchdog all release through the holdoff cycle.
                    if (rw_done || !owner_req_s || timeout_hit_s) begin
                        state_r <= CH_HOLDOFF;
                    end
                end
                CH_HOLDOFF: begin
                    state_r  <= CH_IDLE;
                    rr_ptr_r <= OWN_W'(rr_next(int'(owner_r), NUM_REQ));
                end
                default: begin
                    state_r <= CH_IDLE;
                end
            endcase
        end
    end

    // Sticky watchdog flag; a new timeout outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit_s) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end

    // Owner mux toward the controller and grant-gated returns toward the engines.
    always_comb begin
        grant        = '0;
        gnt_io_valid = '0;
        gnt_mem_out  = '0;
        gnt_rw_done  = '0;
        inst         = SRAM_INST_NONE;
        address      = '0;
        byte_length  = '0;
        write_in     = 1'b0;
        if (state_r == CH_BUSY) begin
            grant[owner_r]        = 1'b1;
            gnt_io_valid[owner_r] = io_valid;
            gnt_mem_out[owner_r]  = mem_out;
            gnt_rw_done[owner_r]  = rw_done;
            if (owner_req_s) begin
                inst        = req_inst[int'(owner_r)*SRAM_INST_W +: SRAM_INST_W];
                address     = req_address[int'(owner_r)*ADDR_W +: ADDR_W];
                byte_length = req_byte_length[int'(owner_r)*ADDR_W +: ADDR_W];
                write_in    = req_write_in[owner_r];
            end else begin
                inst        = SRAM_INST_NONE;
                address     = '0;
                byte_length = '0;
                write_in    = 1'b0;
            end
        end else begin
            grant        = '0;
            gnt_io_valid = '0;
        end
    end

endmodule

// File: rtl/sram_channel_arbiter.sv
// Shares the SRAM controller channels between engines; one independent slot per channel.
module sram_channel_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int NUM_CH         = 4,
    parameter int ADDR_W         = SRAM_ADDR_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_channel_arbiter_if.slave bus,
    output logic [NUM_CH-1:0]     timeout_err,
    input  logic                  err_clr
);

    logic [NUM_CH-1:0][NUM_REQ-1:0]             ch_req_s;
    logic [NUM_CH-1:0][NUM_REQ*SRAM_INST_W-1:0] ch_req_inst_s;
    logic [NUM_CH-1:0][NUM_REQ*ADDR_W-1:0]      ch_req_addr_s;
    logic [NUM_CH-1:0][NUM_REQ*ADDR_W-1:0]      ch_req_len_s;
    logic [NUM_CH-1:0][NUM_REQ-1:0]             ch_req_wr_s;
    logic [NUM_CH-1:0][NUM_REQ-1:0]             ch_grant_s;
    logic [NUM_CH-1:0][NUM_REQ-1:0]             ch_iov_s;
    logic [NUM_CH-1:0][NUM_REQ-1:0]             ch_mem_s;
    logic [NUM_CH-1:0][NUM_REQ-1:0]             ch_done_s;
    logic [NUM_CH-1:0][SRAM_INST_W-1:0]         ch_inst_s;
    logic [NUM_CH-1:0][ADDR_W-1:0]              ch_addr_s;
    logic [NUM_CH-1:0][ADDR_W-1:0]              ch_len_s;
    logic [NUM_CH-1:0]                          ch_wr_s;
    logic [NUM_CH-1:0]                          ch_err_s;

    // Regroup the requester-major request buses into per-channel bundles.
    always_comb begin
        ch_req_s      = '0;
        ch_req_inst_s = '0;
        ch_req_addr_s = '0;
        ch_req_len_s  = '0;
        ch_req_wr_s   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                ch_req_s[c][r]    = bus.req[r*NUM_CH+c];
                ch_req_wr_s[c][r] = bus.req_write_in[r*NUM_CH+c];
                ch_req_inst_s[c][r*SRAM_INST_W +: SRAM_INST_W] =
                    bus.req_inst[(r*NUM_CH+c)*SRAM_INST_W +: SRAM_INST_W];
                ch_req_addr_s[c][r*ADDR_W +: ADDR_W] = bus.req_address[(r*NUM_CH+c)*ADDR_W +: ADDR_W];
                ch_req_len_s[c][r*ADDR_W +: ADDR_W]  = bus.req_byte_length[(r*NUM_CH+c)*ADDR_W +: ADDR_W];
            end
        end
    end

    // Scatter per-channel grants and returns back to requester-major order.
    always_comb begin
        bus.grant        = '0;
        bus.gnt_io_valid = '0;
        bus.gnt_mem_out  = '0;
        bus.gnt_rw_done  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                bus.grant[r*NUM_CH+c]        = ch_grant_s[c][r];
                bus.gnt_io_valid[r*NUM_CH+c] = ch_iov_s[c][r];
                bus.gnt_mem_out[r*NUM_CH+c]  = ch_mem_s[c][r];
                bus.gnt_rw_done[r*NUM_CH+c]  = ch_done_s[c][r];
            end
        end
    end

    assign bus.inst        = ch_inst_s;
    assign bus.address     = ch_addr_s;
    assign bus.byte_length = ch_len_s;
    assign bus.write_in    = ch_wr_s;
    assign timeout_err     = ch_err_s;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
        sram_channel_slot #(
            .NUM_REQ        (NUM_REQ),
            .ADDR_W         (ADDR_W),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_slot (
            .clk             (clk),
            .rst_n           (rst_n),
            .req             (ch_req_s[c]),
            .req_inst        (ch_req_inst_s[c]),
            .req_address     (ch_req_addr_s[c]),
            .req_byte_length (ch_req_len_s[c]),
            .req_write_in    (ch_req_wr_s[c]),
            .io_valid        (bus.io_valid[c]),
            .mem_out         (bus.mem_out[c]),
            .rw_done         (bus.rw_done[c]),
            .err_clr         (err_clr),
            .grant           (ch_grant_s[c]),
            .gnt_io_valid    (ch_iov_s[c]),
            .gnt_mem_out     (ch_mem_s[c]),
            .gnt_rw_done     (ch_done_s[c]),
            .inst            (ch_inst_s[c]),
            .address         (ch_addr_s[c]),
            .byte_length     (ch_len_s[c]),
            .write_in        (ch_wr_s[c]),
            .timeout_err     (ch_err_s[c])
        );
    end

endmodule

// File: tb/tb_sram_channel_arbiter.sv
// Directed vector bench for sram_channel_arbiter with 3 requesters, 4 channels, 16-cycle watchdog.
module tb_sram_channel_arbiter;
    import sram_arb_pkg::*;

    localparam int NR = 3;
    localparam int NC = 4;
    localparam int AW = 24;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          err_clr;
    logic [NC-1:0] timeout_err;
    int            n_checks = 0;
    int            n_pass   = 0;

    sram_channel_arbiter_if #(.NUM_REQ(NR), .NUM_CH(NC), .ADDR_W(AW)) bus ();

    sram_channel_arbiter #(
        .NUM_REQ(NR), .NUM_CH(NC), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // own: one nibble per channel {ch3,ch2,ch1,ch0}, value = owning requester, F = no owner.
    typedef struct {
        string       name;
        logic [11:0] req;
        logic [3:0]  iov;
        logic [3:0]  mem;
        logic [3:0]  done;
        logic [15:0] own;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [7:0] cfg_inst(input int r, input int c);
        return (r == 2) ? SRAM_INST_WRITE : SRAM_INST_READ;
    endfunction
    function automatic logic [23:0] cfg_addr(input int r, input int c);
        return 24'(r * 65536 + c * 256);
    endfunction
    function automatic logic [23:0] cfg_len(input int r, input int c);
        return 24'(49136 + r * 4096 + c * 16);
    endfunction
    function automatic logic cfg_wr(input int r, input int c);
        return 1'((r + c) % 2);
    endfunction

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    task automatic add(input string n, input logic [11:0] rq, input logic [3:0] iv,
                       input logic [3:0] mm, input logic [3:0] dn, input logic [15:0] ow);
        vec_t v;
        v.name = n; v.req = rq; v.iov = iv; v.mem = mm; v.done = dn; v.own = ow;
        vecs.push_back(v);
    endtask

    // Drive one cycle at the falling edge, check the expected routing, move to the next falling edge.
    task automatic apply(input string n, input logic [11:0] rq, input logic [3:0] iv,
                         input logic [3:0] mm, input logic [3:0] dn, input logic [15:0] ow);
        logic [11:0] eg, eiov, emem, edone;
        logic [31:0] einst;
        logic [95:0] eaddr, elen;
        logic [3:0]  ewr, o;
        int          r;
        bus.req = rq; bus.io_valid = iv; bus.mem_out = mm; bus.rw_done = dn;
        eg = '0; eiov = '0; emem = '0; edone = '0; einst = '0; eaddr = '0; elen = '0; ewr = '0;
        for (int c = 0; c < NC; c++) begin
            o = ow[c*4 +: 4];
            if (o != 4'hF) begin
                r = int'(o);
                eg[r*NC+c]    = 1'b1;
                eiov[r*NC+c]  = iv[c];
                emem[r*NC+c]  = mm[c];
                edone[r*NC+c] = dn[c];
                if (rq[r*NC+c]) begin
                    einst[c*8 +: 8]   = cfg_inst(r, c);
                    eaddr[c*AW +: AW] = cfg_addr(r, c);
                    elen[c*AW +: AW]  = cfg_len(r, c);
                    ewr[c]            = cfg_wr(r, c);
                end
            end
        end
        #1;
        chk({n, ".grant"},        128'(bus.grant),        128'(eg));
        chk({n, ".gnt_io_valid"}, 128'(bus.gnt_io_valid), 128'(eiov));
        chk({n, ".gnt_mem_out"},  128'(bus.gnt_mem_out),  128'(emem));
        chk({n, ".gnt_rw_done"},  128'(bus.gnt_rw_done),  128'(edone));
        chk({n, ".inst"},         128'(bus.inst),         128'(einst));
        chk({n, ".address"},      128'(bus.address),      128'(eaddr));
        chk({n, ".byte_length"},  128'(bus.byte_length),  128'(elen));
        chk({n, ".write_in"},     128'(bus.write_in),     128'(ewr));
        chk({n, ".timeout_err"},  128'(timeout_err),      128'(4'h0));
        @(negedge clk);
    endtask

    // r1 holds ch1 without completing; count granted cycles until the watchdog releases it.
    task automatic run_timeout(input string n, input bit clr_at_hit);
        int gcyc;
        bit dropped;
        gcyc = 0; dropped = 1'b0;
        bus.req = 12'h020;
        for (int k = 0; k < 40 && !dropped; k++) begin
            @(negedge clk); #1;
            if (bus.grant[5]) begin
                gcyc++;
                if (clr_at_hit && gcyc == TO) err_clr = 1'b1;
            end else if (gcyc > 0) begin
                dropped = 1'b1;
            end
        end
        err_clr = 1'b0;
        chk({n, ".released"},    128'(dropped),     128'(1'b1));
        chk({n, ".owned_cyc"},   128'(gcyc),        128'(TO));
        chk({n, ".timeout_err"}, 128'(timeout_err), 128'(4'b0010));
        chk({n, ".inst_off"},    128'(bus.inst),    128'(32'h0));
        bus.req = '0;
        err_clr = 1'b1;
        @(negedge clk); #1;
        err_clr = 1'b0;
        chk({n, ".cleared"},     128'(timeout_err), 128'(4'b0000));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; err_clr = 1'b0;
        bus.req = '0; bus.io_valid = '0; bus.mem_out = '0; bus.rw_done = '0;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                bus.req_inst[(r*NC+c)*8 +: 8]           = cfg_inst(r, c);
                bus.req_address[(r*NC+c)*AW +: AW]      = cfg_addr(r, c);
                bus.req_byte_length[(r*NC+c)*AW +: AW]  = cfg_len(r, c);
                bus.req_write_in[r*NC+c]                = cfg_wr(r, c);
            end
        end

        // single job r0/ch1, then stray returns on idle channels
        add("s_idle",  12'h000, 4'h0, 4'h0, 4'h0, 16'hFFFF);
        add("s_req",   12'h002, 4'h0, 4'h0, 4'h0, 16'hFFFF);
        add("s_own",   12'h002, 4'h0, 4'h0, 4'h0, 16'hFF0F);
        add("s_data",  12'h002, 4'h2, 4'h2, 4'h0, 16'hFF0F);
        add("s_done",  12'h002, 4'h0, 4'h0, 4'h2, 16'hFF0F);
        add("s_hold",  12'h000, 4'h0, 4'h0, 4'h0, 16'hFFFF);
        add("s_stray", 12'h000, 4'hF, 4'hF, 4'hF, 16'hFFFF);
        // three-way contention on ch2, r0 keeps asking throughout
        add("c_req",   12'h444, 4'h0, 4'h0, 4'h0, 16'hFFFF);
        add("c_r0",    12'h444, 4'h0, 4'h0, 4'h0, 16'hF0FF);
        add("c_r0d",   12'h444, 4'h0, 4'h0, 4'h4, 16'hF0FF);
        add("c_h0",    12'h444, 4'h0, 4'h0, 4'h0, 16'hFFFF);
        add("c_i0",    12'h444, 4'h0, 4'h0, 4'h0, 16'hFFFF);
        add("c_r1",    12'h444, 4'h0, 4'h0, 4'h0, 16'hF1FF);
        add("c_r1d",   12'h444, 4'h0, 4'h0, 4'h4, 16'hF1FF);
        add("c_h1",    12'h404, 4'h0, 4'h0, 4'h0, 16'hFFFF);
        add("c_i1",    12'h404, 4'h0, 4'h0, 4'h0, 16'hFFFF);
        add("c_r2",    12'h404, 4'h0, 4'h0, 4'h0, 16'hF2FF);
        add("c_r2d",   12'h404, 4'h0, 4'h0, 4'h4, 16'hF2FF);
        add("c_h2",    12'h004, 4'h0, 4'h0, 4'h0, 16'hFFFF);
        add("c_i2",    12'h004, 4'h0, 4'h0, 4'h0, 16'hFFFF);
        add("c_r0b",   12'h004, 4'h0, 4'h0, 4'h0, 16'hF0FF);
        add("c_r0bd",  12'h004, 4'h0, 4'h0, 4'h4, 16'hF0FF);
        add("c_end",   12'h000, 4'h0, 4'h0, 4'h0, 16'hFFFF);
        // return isolation on ch3 owned by r1
        add("i_req",   12'h080, 4'h0, 4'h0, 4'h0, 16'hFFFF);
        add("i_iov",   12'h080, 4'h8, 4'h0, 4'h0, 16'h1FFF);
        add("i_mem",   12'h080, 4'h0, 4'h8, 4'h0, 16'h1FFF);
        add("i_both",  12'h080, 4'hF, 4'hF, 4'h0, 16'h1FFF);
        add("i_done",  12'h080, 4'h0, 4'h0, 4'h8, 16'h1FFF);
        add("i_hold",  12'h000, 4'h0, 4'h0, 4'h0, 16'hFFFF);
        // abort on ch0 by r2 with r0 pending
        add("a_req",   12'h100, 4'h0, 4'h0, 4'h0, 16'hFFFF);
        add("a_own",   12'h101, 4'h0, 4'h0, 4'h0, 16'hFFF2);
        add("a_abort", 12'h001, 4'h0, 4'h0, 4'h0, 16'hFFF2);
        add("a_hold",  12'h001, 4'h0, 4'h0, 4'h0, 16'hFFFF);
        add("a_idle",  12'h001, 4'h0, 4'h0, 4'h0, 16'hFFFF);
        add("a_r0",    12'h001, 4'h0, 4'h0, 4'h0, 16'hFFF0);
        add("a_done",  12'h001, 4'h0, 4'h0, 4'h1, 16'hFFF0);
        add("a_end",   12'h000, 4'h0, 4'h0, 4'h0, 16'hFFFF);

        repeat (2) @(negedge clk);
        apply("rst", 12'h000, 4'hF, 4'hF, 4'hF, 16'hFFFF);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].name, vecs[i].req, vecs[i].iov, vecs[i].mem, vecs[i].done, vecs[i].own);
        end

        run_timeout("to_plain", 1'b0);
        run_timeout("to_clr_same", 1'b1);

        // reset while r0 owns three channels at once
        apply("m_req", 12'h007, 4'h0, 4'h0, 4'h0, 16'hFFFF);
        apply("m_own", 12'h007, 4'h0, 4'h0, 4'h0, 16'hF000);
        #2 rst_n = 1'b0;
        #1;
        chk("m_rst.grant",       128'(bus.grant),       128'(12'h000));
        chk("m_rst.inst",        128'(bus.inst),        128'(32'h0));
        chk("m_rst.address",     128'(bus.address),     128'(96'h0));
        chk("m_rst.byte_length", 128'(bus.byte_length), 128'(96'h0));
        chk("m_rst.write_in",    128'(bus.write_in),    128'(4'h0));
        @(negedge clk);
        rst_n = 1'b1;
        apply("m_rel",     12'h407, 4'h0, 4'h0, 4'h0, 16'hFFFF);
        apply("m_regrant", 12'h407, 4'h0, 4'h0, 4'h0, 16'hF000);
        apply("m_busy",    12'h407, 4'h0, 4'h0, 4'h0, 16'hF000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
